// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
//   Round-robin arbiter granting several requesters write access to one
//   shared n-bit register. A grant occupies one WRITE cycle; the register
//   takes the winner's data at the edge that ends WRITE, and the pointer
//   moves past the winner so other pending requesters go next.
//
// Ports
//   clk_i   in   1     clock, all state updates on rising edge
//   rst_i   in   1     synchronous active-high reset
//   req_i   in   m     level write request per requester
//   data_i  in   m*n   packed write data, slice [k*n +: n] is requester k
//   gnt_o   out  m     one-hot grant, high for the single WRITE cycle
//   busy_o  out  1     high while in WRITE
//   y_o     out  n     shared register value
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | scanning req_i; a nonzero request latches a winner
// WRITE | grant/busy asserted; commit winner data and advance ptr

module shared_reg_arbiter #(
  parameter int          n   = 5,
  parameter logic [n-1:0] val = 5'd31,
  parameter int          m   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [m-1:0]     req_i,
  input  logic [m*n-1:0]   data_i,
  output logic [m-1:0]     gnt_o,
  output logic             busy_o,
  output logic [n-1:0]     y_o
);

  localparam int PW = $clog2(m);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] winner_q;
  logic [PW-1:0] pick;
  logic [n-1:0]  y_q;
  logic [n-1:0]  slice [m];

  for (genvar k = 0; k < m; k++) begin : g_slice
    assign slice[k] = data_i[k*n +: n];
  end

  // Walk from the farthest offset back toward ptr so the nearest asserted
  // request (lowest offset from ptr) is the last assignment and wins.
  always_comb begin
    pick = ptr_q;
    for (int i = m - 1; i >= 0; i--) begin
      if (req_i[PW'((int'(ptr_q) + i) % m)]) begin
        pick = PW'((int'(ptr_q) + i) % m);
      end
    end
  end

  // State register plus the datapath registers that move with it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      winner_q <= '0;
      y_q      <= val;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_i != '0) begin
        winner_q <= pick;
      end
      if (state_q == ST_WRITE) begin
        y_q   <= slice[winner_q];
        ptr_q <= (winner_q == PW'(m - 1)) ? '0 : winner_q + 1'b1;
      end
    end
  end

  // Next-state logic; req_i is ignored while in WRITE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_i != '0) state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    gnt_o  = '0;
    busy_o = 1'b0;
    if (state_q == ST_WRITE) begin
      gnt_o[winner_q] = 1'b1;
      busy_o          = 1'b1;
    end
  end

  assign y_o = y_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
module tb_shared_reg_arbiter;

  localparam int M   = 4;
  localparam int N   = 5;
  localparam int VAL = 31;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [M-1:0]   req_i;
  logic [M*N-1:0] data_i;
  logic [M-1:0]   gnt_o;
  logic           busy_o;
  logic [N-1:0]   y_o;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_y;
  int m_ptr;
  int m_win;
  bit m_write;

  shared_reg_arbiter #(.n(N), .val(5'd31), .m(M)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req_i  (req_i),
    .data_i (data_i),
    .gnt_o  (gnt_o),
    .busy_o (busy_o),
    .y_o    (y_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int slice_of(input logic [M*N-1:0] d, input int k);
    return int'((d >> (k * N)) & ((1 << N) - 1));
  endfunction

  function automatic int rr_pick(input logic [M-1:0] r, input int p);
    for (int i = 0; i < M; i++) begin
      if (r[(p + i) % M]) return (p + i) % M;
    end
    return -1;
  endfunction

  // Advance the model by one clock edge using the inputs present at it.
  task automatic model_edge(input bit r, input logic [M-1:0] q, input logic [M*N-1:0] d);
    if (r) begin
      m_y = VAL; m_ptr = 0; m_write = 0;
    end else if (m_write) begin
      m_y     = slice_of(d, m_win);
      m_ptr   = (m_win + 1) % M;
      m_write = 0;
    end else if (q != 0) begin
      m_win   = rr_pick(q, m_ptr);
      m_write = 1;
    end
  endtask

  task automatic cyc(input bit r, input logic [M-1:0] q, input logic [M*N-1:0] d);
    @(negedge clk_i);
    rst_i = r; req_i = q; data_i = d;
    @(posedge clk_i);
    model_edge(r, q, d);
    #1;
    chk("model_gnt",  int'(gnt_o),  m_write ? (1 << m_win) : 0);
    chk("model_busy", int'(busy_o), int'(m_write));
    chk("model_y",    int'(y_o),    m_y);
  endtask

  function automatic logic [M*N-1:0] pack(input int d0, input int d1, input int d2, input int d3);
    return {N'(d3), N'(d2), N'(d1), N'(d0)};
  endfunction

  logic [M-1:0] exp_seq [5];
  int           exp_y   [5];

  initial begin
    rst_i = 1'b1; req_i = '0; data_i = '0;
    m_y = 0; m_ptr = 0; m_win = 0; m_write = 0;

    // reset state
    cyc(1, 4'b0000, '0);
    chk("rst_y", int'(y_o), 31);
    chk("rst_gnt", int'(gnt_o), 0);
    chk("rst_busy", int'(busy_o), 0);

    // all four requesting: round-robin from bit 0, one grant per two cycles
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    exp_y[0] = 10; exp_y[1] = 11; exp_y[2] = 12; exp_y[3] = 13; exp_y[4] = 10;
    for (int g = 0; g < 5; g++) begin
      cyc(0, 4'b1111, pack(10, 11, 12, 13));
      chk("rr_gnt", int'(gnt_o), int'(exp_seq[g]));
      chk("rr_busy", int'(busy_o), 1);
      cyc(0, 4'b1111, pack(10, 11, 12, 13));
      chk("rr_gap_gnt", int'(gnt_o), 0);
      chk("rr_y", int'(y_o), exp_y[g]);
    end

    // single request latency
    cyc(1, 4'b0000, '0);
    cyc(0, 4'b0010, pack(0, 5, 0, 0));
    chk("lat_gnt", int'(gnt_o), 4'b0010);
    chk("lat_y_hold", int'(y_o), 31);
    cyc(0, 4'b0000, pack(0, 5, 0, 0));
    chk("lat_y", int'(y_o), 5);
    chk("lat_gnt_off", int'(gnt_o), 0);

    // ptr now 2: requester 3 ahead of requester 0
    cyc(0, 4'b1001, pack(1, 0, 0, 2));
    chk("ptr_first", int'(gnt_o), 4'b1000);
    cyc(0, 4'b1001, pack(1, 0, 0, 2));
    chk("ptr_first_y", int'(y_o), 2);
    cyc(0, 4'b1001, pack(1, 0, 0, 2));
    chk("ptr_second", int'(gnt_o), 4'b0001);
    cyc(0, 4'b0000, pack(1, 0, 0, 2));
    chk("ptr_second_y", int'(y_o), 1);

    // reset during WRITE aborts the write
    cyc(0, 4'b0001, pack(7, 0, 0, 0));
    chk("abort_gnt", int'(gnt_o), 4'b0001);
    cyc(1, 4'b0001, pack(7, 0, 0, 0));
    chk("abort_y", int'(y_o), 31);
    cyc(0, 4'b0100, pack(0, 0, 9, 0));
    chk("abort_next", int'(gnt_o), 4'b0100);
    cyc(0, 4'b0000, pack(0, 0, 9, 0));
    chk("abort_next_y", int'(y_o), 9);

    // winner drops request during WRITE; write still commits
    cyc(0, 4'b0100, pack(0, 0, 3, 0));
    cyc(0, 4'b0000, pack(0, 0, 3, 0));
    chk("drop_y", int'(y_o), 3);
    cyc(0, 4'b0000, pack(0, 0, 3, 0));
    chk("drop_nogrant", int'(gnt_o), 0);

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      bit           r;
      logic [M-1:0] q;
      r = ($urandom_range(0, 39) == 0);
      q = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      cyc(r, q, (M*N)'($urandom));
      if (gnt_o != 0) chk("onehot", int'($countones(gnt_o)), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
